// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with enable, registered copy, change strobe and
// optional per-line saturating hit counters (enabled by DEC2TO4_HIT_CNT_EN).
`ifdef DEC2TO4_HIT_CNT_EN
module dec2to4_hit_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hit,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Saturate at all-ones; a held selection keeps counting until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_hit && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule
`endif

module decoder_2to4 #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               a,
  input  logic               b,
  output logic [3:0]         de2to4_result,
  output logic [3:0]         de2to4_q,
  output logic               chg,
  output logic [4*CNT_W-1:0] hit_cnt
);
  logic [1:0] w_code;
  logic [3:0] r_q;
  logic       r_chg;

  assign w_code = {a, b};

  always_comb begin
    de2to4_result = '0;
    if (en) de2to4_result[w_code] = 1'b1;
  end

  // chg compares the incoming decode against the value being replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_chg <= 1'b0;
    end else begin
      r_q   <= de2to4_result;
      r_chg <= (de2to4_result != r_q);
    end
  end

  assign de2to4_q = r_q;
  assign chg      = r_chg;

`ifdef DEC2TO4_HIT_CNT_EN
  for (genvar i = 0; i < 4; i++) begin : g_line
    dec2to4_hit_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_hit (de2to4_result[i]),
      .o_cnt (hit_cnt[i*CNT_W +: CNT_W])
    );
  end
`else
  assign hit_cnt = '0;
`endif
endmodule

// File: tb/tb_decoder_2to4.sv
// Directed + randomized bench for decoder_2to4 against a behavioural model
// (hit counters expected only when DEC2TO4_HIT_CNT_EN is defined).
module tb_decoder_2to4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst, en, a, b;
  logic [3:0]         de2to4_result, de2to4_q;
  logic               chg;
  logic [4*CNT_W-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0] m_q;
  logic       m_chg;
  int         m_cnt [4];

  decoder_2to4 #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .a             (a),
    .b             (b),
    .de2to4_result (de2to4_result),
    .de2to4_q      (de2to4_q),
    .chg           (chg),
    .hit_cnt       (hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_res();
    int code;
    code = (a ? 2 : 0) + (b ? 1 : 0);
    return en ? 4'(1 << code) : 4'b0000;
  endfunction

  function automatic logic [4*CNT_W-1:0] m_hit();
    logic [4*CNT_W-1:0] h;
    h = '0;
`ifdef DEC2TO4_HIT_CNT_EN
    for (int i = 0; i < 4; i++) h[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_res"}, 32'(de2to4_result), 32'(m_res()));
    chk({tag, "_q"},   32'(de2to4_q),      32'(m_q));
    chk({tag, "_chg"}, 32'(chg),           32'(m_chg));
    chk({tag, "_hit"}, 32'(hit_cnt),       32'(m_hit()));
  endtask

  task automatic m_clear();
    m_q = '0; m_chg = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic drive(input logic e, input logic ia, input logic ib, input string tag);
    en = e; a = ia; b = ib;
    #1;
    chk_all(tag);
  endtask

  // One edge: model samples inputs at the edge, then outputs are checked 1 later.
  task automatic cycle(input string tag);
    logic [3:0] r;
    @(posedge clk);
    r = m_res();
    if (rst) m_clear();
    else begin
      m_chg = (r != m_q);
      m_q   = r;
      for (int i = 0; i < 4; i++)
        if (r[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    m_clear();
    rst = 1'b1; en = 1'b1; a = 1'b0; b = 1'b0;
    #2;
    // combinational sweep under reset
    drive(1, 0, 0, "sweep00");
    drive(1, 0, 1, "sweep01");
    drive(1, 1, 0, "sweep10");
    drive(1, 1, 1, "sweep11");
    // enable gating
    drive(0, 0, 0, "gate00");
    drive(0, 0, 1, "gate01");
    drive(0, 1, 0, "gate10");
    drive(0, 1, 1, "gate11");
    cycle("gate_rst_edge");
    rst = 1'b0;
    cycle("gate_edge");
    // registered path
    drive(1, 1, 0, "reg_in");
    cycle("reg_first");
    cycle("reg_hold");
    // saturation on line 3
    drive(1, 1, 1, "sat_in");
    for (int n = 0; n < 5; n++) cycle("sat_hold");
    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    m_clear();
    chk_all("async_rst");
    chk("async_rst_res_1000", 32'(de2to4_result), 32'h8);
    @(negedge clk);
    rst = 1'b0;
    // en fall together with code change while q is non-zero
    drive(1, 0, 1, "sim_in");
    cycle("sim_load");
    drive(0, 1, 0, "sim_fall");
    cycle("sim_edge");
    chk("sim_q_zero", 32'(de2to4_q), 32'h0);
    chk("sim_chg_one", 32'(chg), 32'h1);
    // randomized
    for (int n = 0; n < 200; n++) begin
      logic re;
      re = ($urandom_range(0, 3) != 0);
      drive(re, 1'($urandom), 1'($urandom), "rnd_in");
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        #1;
        m_clear();
        chk_all("rnd_rst");
        cycle("rnd_rst_edge");
        rst = 1'b0;
      end else begin
        cycle("rnd");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
